// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (SD command) over a 40-bit frame, MSB first; result pulse 41 cycles after start.
// No backpressure: startcrc is accepted only in IDLE/DONE and ignored while busy.
module crc7_serial #(
    parameter logic [6:0] POLY = 7'h09
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        startcrc,
    input  logic [39:0] incrc,
    output logic        rdystart,
    output logic [6:0]  crccode,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [39:0] shreg_q;
    logic [6:0]  crc_q;
    logic [5:0]  cnt_q;
    logic        rdystart_q;
    logic        busy_q;
    logic [6:0]  crccode_q;

    logic        fb;
    logic [6:0]  crc_d;

    assign fb    = crc_q[6] ^ shreg_q[39];
    assign crc_d = {crc_q[5:0], 1'b0} ^ (fb ? POLY : 7'h00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            crc_q      <= '0;
            cnt_q      <= '0;
            rdystart_q <= 1'b0;
            busy_q     <= 1'b0;
            crccode_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    rdystart_q <= 1'b0;
                    if (startcrc) begin
                        shreg_q <= incrc;
                        crc_q   <= '0;
                        cnt_q   <= 6'd39;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    crc_q   <= crc_d;
                    shreg_q <= {shreg_q[38:0], 1'b0};
                    // The edge that consumes bit 0 also publishes the final remainder.
                    if (cnt_q == 6'd0) begin
                        crccode_q  <= crc_d;
                        rdystart_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                default: begin
                    rdystart_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign rdystart = rdystart_q;
    assign crccode  = crccode_q;
    assign busy     = busy_q;

endmodule
